// File: rtl/psum_ofifo.sv
// -----------------------------------------------------------------------------
// psum_ofifo
//
// Output collection stage behind the chained mac_col columns. Each column
// writes its psum on its own cycle (one cycle of skew per column), so every
// column gets an independent FIFO. A full row is offered only when every
// column holds at least one entry; a row read pops all columns together and
// presents the row on a registered output one cycle later.
//
// Optional feature (macro PSUM_OFIFO_DROP_CNT_EN):
//   adds a 16-bit saturating drop counter output, drop_cnt.
//
// Parameters:
//   col      number of mac_col columns collected
//   bw_psum  width of one column psum
//   depth    entries per column FIFO (power of 2, >= 2)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   in         column c psum on [c*bw_psum +: bw_psum]
//   wr         per-column write strobe
//   rd         row read request
//   o_valid    every column FIFO is non-empty (combinational)
//   o_full     at least one column FIFO is full
//   out        registered row, column c on [c*bw_psum +: bw_psum]
//   out_valid  one-cycle pulse: out holds a newly popped row
//   o_ovf      sticky: a write was dropped since reset
//   drop_cnt   (optional) number of dropped writes, saturating
// -----------------------------------------------------------------------------
module psum_ofifo #(
    parameter int col     = 8,
    parameter int bw_psum = 32,
    parameter int depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*bw_psum-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [col*bw_psum-1:0] out,
    output logic                   out_valid,
    output logic                   o_ovf
`ifdef PSUM_OFIFO_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int AW = $clog2(depth);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    ptr_t wr_ptr_q [col];
    ptr_t wr_ptr_d [col];
    ptr_t rd_ptr_q [col];
    ptr_t rd_ptr_d [col];
    cnt_t count_q  [col];
    cnt_t count_d  [col];

    logic [bw_psum-1:0] mem_q [col][depth];

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         push;
    logic [col-1:0]         drop;
    logic                   pop;
    logic [col*bw_psum-1:0] head_row;
    logic [col*bw_psum-1:0] out_q;
    logic                   out_valid_q;
    logic                   ovf_q;
    logic                   ovf_d;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        empty = '0;
        full  = '0;
        for (int c = 0; c < col; c++) begin
            empty[c] = (count_q[c] == '0);
            full[c]  = (count_q[c] == cnt_t'(depth));
        end
    end

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign pop     = rd & o_valid;

    // A full column may still accept a write in the cycle it is popped.
    assign push = wr & (~full | {col{pop}});
    assign drop = wr & full & {col{~pop}};

    always_comb begin
        head_row = '0;
        for (int c = 0; c < col; c++) begin
            wr_ptr_d[c] = push[c] ? wr_ptr_q[c] + ptr_t'(1) : wr_ptr_q[c];
            rd_ptr_d[c] = pop     ? rd_ptr_q[c] + ptr_t'(1) : rd_ptr_q[c];
            case ({push[c], pop})
                2'b10:   count_d[c] = count_q[c] + cnt_t'(1);
                2'b01:   count_d[c] = count_q[c] - cnt_t'(1);
                default: count_d[c] = count_q[c];
            endcase
            head_row[c*bw_psum +: bw_psum] = mem_q[c][rd_ptr_q[c]];
        end
        ovf_d = ovf_q | (|drop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < col; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
            out_valid_q <= pop;
            if (pop) begin
                out_q <= head_row;
            end
            ovf_q <= ovf_d;
        end
    end

    // NOTE: storage has no reset; counts gate every read, so stale contents
    // are never observable and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= in[c*bw_psum +: bw_psum];
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign o_ovf     = ovf_q;

`ifdef PSUM_OFIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] drop_cnt_d;
    logic [16:0] drop_sum;

    // One spare bit catches the carry so the count can clamp at all-ones.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int c = 0; c < col; c++) begin
            drop_sum = drop_sum + 17'(drop[c]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
